mu0_cpu: RTL and testbench

Parametrised, handshake-driven successor to the fixed-width MU0 core. It executes the eight-instruction MU0 ISA at configurable data width and talks to an external memory through a req/ack port, so it runs against zero-wait or multi-cycle memory alike. It adds run/halt control, single-stepping and illegal-opcode trapping, and sits between the memory/LED subsystem and the host or debug controller.

---
 rtl/mu0_cpu.sv | 197 +++++++++++++++++++
 tb/tb_mu0_cpu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_cpu.sv
// mu0_cpu: parametrised MU0 core with a req/ack memory port, run/halt
// control, single-stepping and a sticky illegal-opcode flag.
//
// state | meaning
// IDLE  | halted, no memory request, waits for start
// FETCH | reading the instruction at PC
// EXEC  | decoding IR, resolves jumps/STP/illegal directly
// MEM   | data access for LDA/STO/ADD/SUB at address S
module mu0_cpu #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = DATA_W - 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              halt_req_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              halted_o,
    output logic              done_o,
    output logic              illegal_o,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic [DATA_W-1:0] acc_out_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM} state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                halted_q, halted_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          op_w;
    logic [DATA_W-5:0]   s_w;
    logic                take_w;

    assign op_w = ir_q[DATA_W-1:DATA_W-4];
    assign s_w  = ir_q[DATA_W-5:0];

    // Next-state and next-output logic; bus outputs are computed one cycle
    // ahead so that they come straight from flops and hold through waits.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        illegal_d   = illegal_q;
        take_w      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_FETCH;
                    illegal_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end
            end
            S_FETCH: begin
                if (mem_ack_i) begin
                    ir_d      = mem_rdata_i;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = S_EXEC;
                    mem_req_d = 1'b0;
                end
            end
            S_EXEC: begin
                case (op_w)
                    OP_LDA, OP_STO, OP_ADD, OP_SUB: begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op_w == OP_STO);
                        mem_addr_d  = ADDR_W'(s_w);
                        mem_wdata_d = acc_q;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        take_w = (op_w == OP_JMP)
                              || ((op_w == OP_JGE) && !acc_q[DATA_W-1])
                              || ((op_w == OP_JNE) && (acc_q != '0));
                        if (take_w) begin
                            pc_d = ADDR_W'(s_w);
                        end
                        if (halt_req_i) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_FETCH;
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b0;
                            mem_addr_d = pc_d;
                        end
                    end
                    OP_STP: begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    case (op_w)
                        OP_LDA:  acc_d = mem_rdata_i;
                        OP_ADD:  acc_d = acc_q + mem_rdata_i;
                        OP_SUB:  acc_d = acc_q - mem_rdata_i;
                        default: acc_d = acc_q;
                    endcase
                    mem_we_d = 1'b0;
                    if (halt_req_i) begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d    = S_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        halted_d = (state_d == S_IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            acc_q       <= '0;
            ir_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b1;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign halted_o    = halted_q;
    assign done_o      = done_q;
    assign illegal_o   = illegal_q;
    assign pc_out_o    = pc_q;
    assign acc_out_o   = acc_q;

endmodule

// File: tb/tb_mu0_cpu.sv
// Directed testbench for mu0_cpu with a behavioural req/ack memory.
module tb_mu0_cpu;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        halted;
    logic        done;
    logic        illegal;
    logic [11:0] pc_out;
    logic [15:0] acc_out;

    logic [15:0] mem [0:4095];
    int          n_wait;
    logic        blk_wr;
    int          wait_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    int done_cnt  = 0;
    int wr_cnt    = 0;
    int rd21_cnt  = 0;
    int stab_cmp  = 0;
    int stab_err  = 0;
    logic        pend = 1'b0;
    logic        p_we;
    logic [11:0] p_addr;
    logic [15:0] p_wd;

    mu0_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .halt_req_i  (halt_req),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .halted_o    (halted),
        .done_o      (done),
        .illegal_o   (illegal),
        .pc_out_o    (pc_out),
        .acc_out_o   (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && !(blk_wr && mem_we) && (wait_cnt >= n_wait);

    // Wait-state counter for the memory model.
    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    // Event counters: done pulses, completed writes, reads of word 0x21.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req && mem_we && mem_ack) wr_cnt <= wr_cnt + 1;
        if (mem_req && !mem_we && mem_ack && mem_addr == 12'h021) rd21_cnt <= rd21_cnt + 1;
    end

    // Request signals must hold while a transaction is waiting for ack.
    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                stab_cmp <= stab_cmp + 1;
                if (!(mem_req && mem_we == p_we && mem_addr == p_addr && mem_wdata == p_wd))
                    stab_err <= stab_err + 1;
            end
            pend   <= mem_req && !mem_ack;
            p_we   <= mem_we;
            p_addr <= mem_addr;
            p_wd   <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Pulse start, then count edges until halted rises (bounded).
    task automatic run(input int max, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    int cyc;
    int d0, w0, r0, s0;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        n_wait   = 0;
        blk_wr   = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

        fork
            forever begin
                @(posedge clk);
                if (mem_req && mem_we && mem_ack) mem[mem_addr] = mem_wdata;
            end
        join_none

        do_reset();
        check("rst_halted",  halted,    1);
        check("rst_req",     mem_req,   0);
        check("rst_we",      mem_we,    0);
        check("rst_addr",    mem_addr,  0);
        check("rst_wdata",   mem_wdata, 0);
        check("rst_pc",      pc_out,    0);
        check("rst_acc",     acc_out,   0);
        check("rst_done",    done,      0);
        check("rst_illegal", illegal,   0);

        // Basic program, zero-wait memory
        mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
        mem[16'h10] = 16'd5; mem[16'h11] = 16'd7; mem[16'h12] = 16'd0;
        d0 = done_cnt;
        run(100, cyc);
        check("basic_cycles", cyc, 11);
        check("basic_done_now", done, 1);
        @(posedge clk); #1;
        check("basic_done_gone", done, 0);
        check("basic_done_cnt", done_cnt - d0, 1);
        check("basic_mem12", mem[16'h12], 12);
        check("basic_acc", acc_out, 12);
        check("basic_pc", pc_out, 4);
        check("basic_halted", halted, 1);

        // Same program with three wait cycles per ack
        do_reset();
        mem[16'h12] = 16'd0;
        n_wait = 3;
        s0 = stab_cmp;
        run(200, cyc);
        check("wait_cycles", cyc, 32);
        check("wait_mem12", mem[16'h12], 12);
        check("wait_acc", acc_out, 12);
        check("wait_pc", pc_out, 4);
        check("stab_checked", (stab_cmp - s0) >= 21, 1);
        check("stab_err", stab_err, 0);
        n_wait = 0;

        // SUB/JNE countdown loop from 3
        do_reset();
        mem[0] = 16'h0020; mem[1] = 16'h3021; mem[2] = 16'h6001; mem[3] = 16'h7000;
        mem[16'h20] = 16'd3; mem[16'h21] = 16'd1;
        r0 = rd21_cnt;
        run(200, cyc);
        check("loop_cycles", cyc, 20);
        check("loop_iters", rd21_cnt - r0, 3);
        check("loop_acc", acc_out, 0);
        check("loop_pc", pc_out, 4);

        // JGE with negative ACC: not taken
        do_reset();
        mem[0] = 16'h0020; mem[1] = 16'h5005; mem[2] = 16'h7000; mem[5] = 16'h7000;
        mem[16'h20] = 16'h8000;
        run(100, cyc);
        check("jge_nt_acc", acc_out, 16'h8000);
        check("jge_nt_pc", pc_out, 3);
        // JGE with positive ACC: taken
        do_reset();
        mem[16'h20] = 16'h0001;
        run(100, cyc);
        check("jge_t_pc", pc_out, 6);

        // Illegal opcode
        do_reset();
        mem[0] = 16'h9000; mem[1] = 16'h7000;
        w0 = wr_cnt; d0 = done_cnt;
        run(100, cyc);
        check("ill_cycles", cyc, 2);
        check("ill_flag", illegal, 1);
        check("ill_halted", halted, 1);
        check("ill_pc", pc_out, 1);
        @(posedge clk); #1;
        check("ill_no_write", wr_cnt - w0, 0);
        check("ill_no_done", done_cnt - d0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ill_cleared", illegal, 0);
        cyc = 0;
        while (!halted && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("ill_resume_pc", pc_out, 2);

        // Single step with halt_req held high
        do_reset();
        mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h4008;
        mem[8] = 16'h7000;
        mem[16'h10] = 16'd5; mem[16'h11] = 16'd7; mem[16'h12] = 16'd0;
        halt_req = 1'b1;
        run(100, cyc);
        check("ss1_cycles", cyc, 3);
        check("ss1_pc", pc_out, 1);
        check("ss1_acc", acc_out, 5);
        run(100, cyc);
        check("ss2_pc", pc_out, 2);
        check("ss2_acc", acc_out, 12);
        run(100, cyc);
        check("ss3_pc", pc_out, 3);
        check("ss3_mem12", mem[16'h12], 12);
        run(100, cyc);
        check("ss4_cycles", cyc, 2);
        check("ss4_pc", pc_out, 8);
        halt_req = 1'b0;

        // ADD overflow wraps to zero
        do_reset();
        mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h7000;
        mem[16'h10] = 16'hFFFF; mem[16'h11] = 16'h0001;
        run(100, cyc);
        check("ovf_acc", acc_out, 0);
        check("ovf_pc", pc_out, 3);

        // PC wraps from 0xFFF to 0
        do_reset();
        mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h7000;
        run(100, cyc);
        check("wrap_cycles", cyc, 4);
        check("wrap_pc", pc_out, 0);

        // Reset during a pending write with ack withheld
        do_reset();
        mem[0] = 16'h0010; mem[1] = 16'h1030;
        mem[16'h10] = 16'd5; mem[16'h30] = 16'd0;
        blk_wr = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("pend_req", mem_req, 1);
        check("pend_we", mem_we, 1);
        check("pend_addr", mem_addr, 12'h030);
        check("pend_wdata", mem_wdata, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_req", mem_req, 0);
        check("abort_pc", pc_out, 0);
        check("abort_acc", acc_out, 0);
        check("abort_halted", halted, 1);
        check("abort_mem30", mem[16'h30], 0);
        reset = 1'b0;
        blk_wr = 1'b0;
        check("stab_err_final", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
